// File: rtl/agc_gain_scheduler.sv
// Closed-loop AGC: windowed peak detector, dB-step gain decision and AFE set_gain
// sequencing, with host manual gain requests taking priority over automatic steps.
module agc_gain_scheduler #(
  parameter int unsigned SAMPLE_W      = 12,
  parameter int unsigned WINDOW_LEN    = 1024,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned HI_THRESH     = 1800,
  parameter int unsigned LO_THRESH     = 600,
  parameter int unsigned GAIN_STEP     = 4,
  parameter int          GAIN_MIN      = -8,
  parameter int          GAIN_MAX      = 40,
  parameter int          GAIN_INIT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  input  logic                       agc_en_i,
  input  logic signed [7:0]          manual_gain_dB_i,
  input  logic                       manual_set_i,
  input  logic                       set_in_progress_i,
  output logic signed [7:0]          gain_dB_o,
  output logic                       set_gain_o,
  output logic [SAMPLE_W-1:0]        peak_o,
  output logic                       peak_valid_o,
  output logic                       busy_o
);

  localparam int unsigned WIN_W = $clog2(WINDOW_LEN + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SAMPLE_W-1:0] MAG_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] HI_T     = SAMPLE_W'(HI_THRESH);
  localparam logic [SAMPLE_W-1:0] LO_T     = SAMPLE_W'(LO_THRESH);
  localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic signed [9:0]   G_MIN    = 10'(GAIN_MIN);
  localparam logic signed [9:0]   G_MAX    = 10'(GAIN_MAX);
  localparam logic signed [9:0]   G_STEP   = 10'(GAIN_STEP);

  typedef enum logic [2:0] {
    IDLE, MEASURE, DECIDE, ISSUE, WAIT_START, WAIT_DONE, SETTLE
  } state_e;

  state_e                state_q, state_d;
  logic signed [7:0]     gain_q, gain_d;
  logic                  set_gain_q, set_gain_d;
  logic [SAMPLE_W-1:0]   peak_q, peak_d;
  logic                  peak_valid_q, peak_valid_d;
  logic                  busy_q, busy_d;
  logic [SAMPLE_W-1:0]   acc_q, acc_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [SET_W-1:0]      set_cnt_q, set_cnt_d;
  logic signed [7:0]     pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;

  logic [SAMPLE_W-1:0]   mag_c, max_c;
  logic signed [9:0]     gain_ext_c, tgt_raw_c, tgt_c, man_ext_c, man_clamp_c;
  logic signed [7:0]     man_c, pend_val_c;
  logic                  pend_req_c, service_c;

  function automatic logic signed [9:0] clamp_gain(input logic signed [9:0] v);
    if (v < G_MIN)      return G_MIN;
    else if (v > G_MAX) return G_MAX;
    else                return v;
  endfunction

  // Saturating magnitude and running max
  always_comb begin
    if (!sample_i[SAMPLE_W-1])                mag_c = sample_i;
    else if (sample_i == MOST_NEG)            mag_c = MAG_MAX;
    else                                      mag_c = ~sample_i + SAMPLE_W'(1);
    max_c = (mag_c > acc_q) ? mag_c : acc_q;
  end

  // AGC step target and manual request (clamped; a same-cycle pulse passes straight through)
  always_comb begin
    gain_ext_c = {{2{gain_q[7]}}, gain_q};
    if (peak_q > HI_T)      tgt_raw_c = gain_ext_c - G_STEP;
    else if (peak_q < LO_T) tgt_raw_c = gain_ext_c + G_STEP;
    else                    tgt_raw_c = gain_ext_c;
    tgt_c       = clamp_gain(tgt_raw_c);
    man_ext_c   = {{2{manual_gain_dB_i[7]}}, manual_gain_dB_i};
    man_clamp_c = clamp_gain(man_ext_c);
    man_c       = man_clamp_c[7:0];
    pend_val_c  = manual_set_i ? man_c : pend_q;
    pend_req_c  = manual_set_i | pend_flag_q;
  end

  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    set_gain_d   = 1'b0;
    peak_d       = peak_q;
    peak_valid_d = 1'b0;
    acc_d        = '0;
    win_cnt_d    = '0;
    set_cnt_d    = '0;
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    service_c    = 1'b0;

    if (manual_set_i) begin
      pend_d      = man_c;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_req_c)    service_c = 1'b1;
        else if (agc_en_i) state_d   = MEASURE;
      end
      MEASURE: begin
        if (pend_req_c)     service_c = 1'b1;
        else if (!agc_en_i) state_d   = IDLE;
        else begin
          acc_d     = acc_q;
          win_cnt_d = win_cnt_q;
          if (sample_valid_i) begin
            if (win_cnt_q == WIN_LAST) begin
              peak_d       = max_c;
              peak_valid_d = 1'b1;
              acc_d        = '0;
              win_cnt_d    = '0;
              state_d      = DECIDE;
            end else begin
              acc_d     = max_c;
              win_cnt_d = win_cnt_q + WIN_W'(1);
            end
          end
        end
      end
      DECIDE: begin
        if (pend_req_c) service_c = 1'b1;
        else if (tgt_c != gain_ext_c) begin
          gain_d     = tgt_c[7:0];
          set_gain_d = 1'b1;
          state_d    = ISSUE;
        end else state_d = MEASURE;
      end
      ISSUE:      state_d = WAIT_START;
      WAIT_START: state_d = WAIT_DONE;
      WAIT_DONE:  if (!set_in_progress_i) state_d = SETTLE;
      SETTLE: begin
        // Blanking always runs to completion; a held manual request is issued at its end
        if (set_cnt_q == SET_LAST) begin
          if (pend_req_c)    service_c = 1'b1;
          else if (agc_en_i) state_d   = MEASURE;
          else               state_d   = IDLE;
        end else set_cnt_d = set_cnt_q + SET_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (service_c) begin
      gain_d      = pend_val_c;
      pend_flag_d = 1'b0;
      set_gain_d  = 1'b1;
      acc_d       = '0;
      win_cnt_d   = '0;
      state_d     = ISSUE;
    end

    busy_d = (state_d == ISSUE) || (state_d == WAIT_START) ||
             (state_d == WAIT_DONE) || (state_d == SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gain_q       <= 8'(GAIN_INIT);
      set_gain_q   <= 1'b0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      acc_q        <= '0;
      win_cnt_q    <= '0;
      set_cnt_q    <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      set_gain_q   <= set_gain_d;
      peak_q       <= peak_d;
      peak_valid_q <= peak_valid_d;
      busy_q       <= busy_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
      set_cnt_q    <= set_cnt_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
    end
  end

  assign gain_dB_o    = gain_q;
  assign set_gain_o   = set_gain_q;
  assign peak_o       = peak_q;
  assign peak_valid_o = peak_valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_agc_gain_scheduler.sv
// Scoreboard bench for agc_gain_scheduler: expected peaks and gain issues are queued as
// stimulus is driven and checked when the DUT pulses peak_valid_o / set_gain_o.
module tb_agc_gain_scheduler;

  localparam int unsigned SW  = 12;
  localparam int unsigned WIN = 8;
  localparam int unsigned SET = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [SW-1:0] sample_i;
  logic                 sample_valid_i;
  logic                 agc_en_i;
  logic signed [7:0]    manual_gain_dB_i;
  logic                 manual_set_i;
  logic                 set_in_progress_i;
  logic signed [7:0]    gain_dB_o;
  logic                 set_gain_o;
  logic [SW-1:0]        peak_o;
  logic                 peak_valid_o;
  logic                 busy_o;

  agc_gain_scheduler #(.SAMPLE_W(SW), .WINDOW_LEN(WIN), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .agc_en_i(agc_en_i), .manual_gain_dB_i(manual_gain_dB_i), .manual_set_i(manual_set_i),
    .set_in_progress_i(set_in_progress_i), .gain_dB_o(gain_dB_o), .set_gain_o(set_gain_o),
    .peak_o(peak_o), .peak_valid_o(peak_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int peak_q[$];
  int gain_q[$];
  int gcyc_q[$];
  int exp_gain = 0;
  int afe_len = 5;
  int ip_fall_cyc = 0, last_gap = 0;
  int mon_g, mon_c;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int clampg(input int v);
    if (v < -8) return -8;
    if (v > 40) return 40;
    return v;
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (peak_valid_o) begin
        if (peak_q.size() > 0) check_eq("peak", int'(peak_o), peak_q.pop_front());
        else check_eq("peak_valid_unexpected", int'(peak_valid_o), 0);
      end
      if (set_gain_o) begin
        last_gap = cyc - ip_fall_cyc;
        if (gain_q.size() > 0) begin
          mon_g = gain_q.pop_front();
          mon_c = gcyc_q.pop_front();
          check_eq("gain", int'(gain_dB_o), mon_g);
          if (mon_c >= 0) check_eq("issue_latency", cyc, mon_c);
        end else check_eq("set_gain_unexpected", int'(set_gain_o), 0);
      end
    end
  end

  // AFE gain controller model
  initial begin
    set_in_progress_i = 1'b0;
    forever begin
      @(negedge clk);
      if (set_gain_o && rst_n) begin
        set_in_progress_i = 1'b1;
        repeat (afe_len) @(negedge clk);
        set_in_progress_i = 1'b0;
        ip_fall_cyc = cyc;
      end
    end
  end

  task automatic send_window(input int amp, input bit with_min, input bit expect_out);
    int v, pk, t, last;
    last = 0;
    for (int i = 0; i < int'(WIN); i++) begin
      @(negedge clk);
      v = (i % 2 == 1) ? -amp : amp;
      if (with_min && i == 3) v = -2048;
      sample_i       = SW'(v);
      sample_valid_i = 1'b1;
      last           = cyc;
    end
    if (expect_out) begin
      pk = with_min ? 2047 : amp;
      peak_q.push_back(pk);
      if (pk > 1800)     t = exp_gain - 4;
      else if (pk < 600) t = exp_gain + 4;
      else               t = exp_gain;
      t = clampg(t);
      if (t != exp_gain) begin
        exp_gain = t;
        gain_q.push_back(t);
        gcyc_q.push_back(last + 2);
      end
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy_o && n < 300) begin
      if (noise) begin
        sample_valid_i = 1'b1;
        sample_i       = (n % 2 == 1) ? -SW'(2047) : SW'(2047);
      end
      @(negedge clk);
      n++;
    end
    sample_valid_i = 1'b0;
    check_eq("busy_timeout", int'(busy_o), 0);
  endtask

  task automatic pulse_manual(input int v);
    manual_gain_dB_i = 8'(v);
    manual_set_i     = 1'b1;
    @(negedge clk);
    manual_set_i     = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_gain", int'(gain_dB_o), 0);
    check_eq("rst_set_gain", int'(set_gain_o), 0);
    check_eq("rst_peak", int'(peak_o), 0);
    check_eq("rst_peak_valid", int'(peak_valid_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_i = '0; sample_valid_i = 1'b0; agc_en_i = 1'b0;
    manual_gain_dB_i = '0; manual_set_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Loud: two steps down, then clamped at GAIN_MIN
    agc_en_i = 1'b1;
    @(negedge clk);
    repeat (3) begin
      send_window(2000, 1'b0, 1'b1);
      wait_idle(1'b0);
    end
    check_eq("gain_min", int'(gain_dB_o), -8);

    // Quiet: step up to GAIN_MAX, samples during transaction/settle must be ignored
    for (int i = 0; i < 12; i++) begin
      send_window(100, 1'b0, 1'b1);
      wait_idle(1'b1);
      if (i == 0) check_eq("settle_len", cyc - ip_fall_cyc, int'(SET) + 1);
    end
    check_eq("gain_max", int'(gain_dB_o), 40);
    send_window(100, 1'b0, 1'b1);
    wait_idle(1'b0);
    send_window(100, 1'b1, 1'b1);
    wait_idle(1'b0);

    // In-band
    repeat (2) begin
      send_window(1000, 1'b0, 1'b1);
      wait_idle(1'b0);
    end

    // Manual during WAIT_DONE is issued once SETTLE completes
    afe_len = 10;
    send_window(100, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    gain_q.push_back(20); gcyc_q.push_back(-1); exp_gain = 20;
    pulse_manual(20);
    wait_idle(1'b0);
    check_eq("manual_after_settle", last_gap, int'(SET) + 1);

    // Manual 100 in MEASURE clamps to 40 and issues next cycle; 12 then 16 while busy -> only 16
    gain_q.push_back(40); gcyc_q.push_back(cyc + 1);
    pulse_manual(100);
    repeat (2) @(negedge clk);
    pulse_manual(12);
    @(negedge clk);
    gain_q.push_back(16); gcyc_q.push_back(-1); exp_gain = 16;
    pulse_manual(16);
    wait_idle(1'b0);
    check_eq("manual_last_wins", int'(gain_dB_o), 16);

    // agc_en dropped mid-MEASURE: partial loud window discarded
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid_i = 1'b1;
      sample_i       = SW'(2000);
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
    agc_en_i       = 1'b0;
    repeat (10) @(negedge clk);
    agc_en_i = 1'b1;
    @(negedge clk);
    send_window(1000, 1'b0, 1'b1);
    wait_idle(1'b0);

    // agc_en dropped in WAIT_DONE: transaction completes, then IDLE ignores samples
    send_window(100, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    agc_en_i = 1'b0;
    wait_idle(1'b0);
    send_window(2000, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("idle_gain_hold", int'(gain_dB_o), 20);

    // Reset mid-WAIT_DONE with a pending manual request
    agc_en_i = 1'b1;
    @(negedge clk);
    send_window(100, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    pulse_manual(30);
    rst_n    = 1'b0;
    agc_en_i = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_pulse", int'(set_gain_o), 0);
    end
    rst_n    = 1'b1;
    exp_gain = 0;
    repeat (40) @(negedge clk);
    check_eq("post_rst_gain", int'(gain_dB_o), 0);
    check_eq("post_rst_busy", int'(busy_o), 0);

    check_eq("gain_queue_empty", gain_q.size(), 0);
    check_eq("peak_queue_empty", peak_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
